dmem_lsu: RTL

- Processor-side initiator for the data-memory port: load/store unit in the MEM stage that drives addr, data_in and wrEn, and samples data_out.
- The dmem port is word-wide with a single write enable and no byte strobes. The block therefore sign/zero-extends sub-word loads and performs read-modify-write for byte/half stores.
- Accepts one request at a time from the pipeline over a valid/ready handshake. Returns a single-cycle response pulse.

---
 rtl/dmem_lsu.sv | 215 +++++++++++++++++++++
 1 files changed

// File: rtl/dmem_lsu.sv
`default_nettype none
// ============================================================================
// Module      : dmem_lsu
// Description : MEM-stage load/store unit driving a word-wide data memory
//               that has a single write enable and no byte strobes.
//               Sub-word loads are lane-selected and sign/zero-extended.
//               Byte/half stores are done as read-modify-write.
//               One request is in flight at a time.
//               Completion is a single-cycle rsp_valid pulse.
// Ports       : clk, rst              - clock, async active-high reset
//               req_valid/req_ready   - request handshake
//               req_we/size/unsigned  - access type
//               req_addr/req_wdata    - byte address, right-justified data
//               rsp_valid/rdata/misaligned - completion pulse and result
//               mem_addr/wdata/we     - to dmem (addr, data_in, wrEn)
//               mem_rdata             - from dmem data_out
// Revision    : 1.0 - initial release
// ============================================================================
module dmem_lsu #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32,  // lane logic assumes 32
    parameter int RD_LAT     = 1    // legal range 1..4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic                  req_we,
    input  logic [1:0]            req_size,
    input  logic                  req_unsigned,
    input  logic [ADDR_WIDTH-1:0] req_addr,
    input  logic [DATA_WIDTH-1:0] req_wdata,
    output logic                  rsp_valid,
    output logic [DATA_WIDTH-1:0] rsp_rdata,
    output logic                  rsp_misaligned,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [DATA_WIDTH-1:0] mem_wdata,
    output logic                  mem_we,
    input  logic [DATA_WIDTH-1:0] mem_rdata
);

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_RD_WAIT = 2'd1,
        S_WRITE   = 2'd2,
        S_RESP    = 2'd3
    } state_t;

    // RD_WAIT spans RD_LAT+1 cycles; the counter runs 0..RD_LAT.
    localparam logic [2:0] C_RD_LAST = 3'(RD_LAT);

    state_t                r_state;
    state_t                w_next;

    // Captured request; only the fields still needed after acceptance.
    logic                  r_we;
    logic [1:0]            r_size;
    logic                  r_unsigned;
    logic [1:0]            r_addr_lo;
    logic [15:0]           r_wdata_lo;
    logic                  r_mis;
    logic [2:0]            r_cnt;
    logic [DATA_WIDTH-1:0] r_rdata;
    logic [ADDR_WIDTH-1:0] r_mem_addr;
    logic [DATA_WIDTH-1:0] r_mem_wdata;

    logic                  w_accept;
    logic                  w_rd_done;
    logic                  w_req_mis;
    logic                  w_word_store;
    logic [DATA_WIDTH-1:0] w_merge;
    logic [DATA_WIDTH-1:0] w_load;
    logic [7:0]            w_lane_b;
    logic [15:0]           w_lane_h;

    assign w_req_mis = (req_size == 2'b11) ||
                       ((req_size == 2'b01) && req_addr[0]) ||
                       ((req_size == 2'b10) && (req_addr[1:0] != 2'b00));
    assign w_word_store = req_we && (req_size == 2'b10);

    assign mem_addr  = r_mem_addr;
    assign mem_wdata = r_mem_wdata;

    // ------------------------------------------------------------------------
    // FSM state register
    // ------------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // ------------------------------------------------------------------------
    // Next state and outputs. req_ready and mem_we are gated by rst so that
    // they fall immediately on reset assertion, not at the next edge.
    // ------------------------------------------------------------------------
    always_comb begin
        w_next         = r_state;
        req_ready      = 1'b0;
        mem_we         = 1'b0;
        rsp_valid      = 1'b0;
        rsp_misaligned = 1'b0;
        rsp_rdata      = '0;
        w_accept       = 1'b0;
        w_rd_done      = 1'b0;
        case (r_state)
            S_IDLE: begin
                req_ready = !rst;
                if (req_valid && !rst) begin
                    w_accept = 1'b1;
                    if (w_req_mis) begin
                        w_next = S_RESP;
                    end else if (w_word_store) begin
                        w_next = S_WRITE;
                    end else begin
                        w_next = S_RD_WAIT;
                    end
                end
            end
            S_RD_WAIT: begin
                if (r_cnt == C_RD_LAST) begin
                    w_rd_done = 1'b1;
                    w_next    = r_we ? S_WRITE : S_RESP;
                end
            end
            S_WRITE: begin
                mem_we = !rst;
                w_next = S_RESP;
            end
            S_RESP: begin
                rsp_valid      = 1'b1;
                rsp_misaligned = r_mis;
                rsp_rdata      = (r_we || r_mis) ? '0 : w_load;
                w_next         = S_IDLE;
            end
            default: w_next = S_IDLE;
        endcase
    end

    // ------------------------------------------------------------------------
    // Store merge: replace the addressed lane of the word just read.
    // ------------------------------------------------------------------------
    always_comb begin
        w_merge = mem_rdata;
        if (r_size == 2'b00) begin
            w_merge[{r_addr_lo, 3'b000} +: 8] = r_wdata_lo[7:0];
        end else begin
            w_merge[{r_addr_lo[1], 4'b0000} +: 16] = r_wdata_lo;
        end
    end

    // ------------------------------------------------------------------------
    // Load extraction and extension from the registered read word.
    // ------------------------------------------------------------------------
    always_comb begin
        w_lane_b = r_rdata[{r_addr_lo, 3'b000} +: 8];
        w_lane_h = r_rdata[{r_addr_lo[1], 4'b0000} +: 16];
        case (r_size)
            2'b00:   w_load = r_unsigned ? {{(DATA_WIDTH-8){1'b0}}, w_lane_b}
                                         : {{(DATA_WIDTH-8){w_lane_b[7]}}, w_lane_b};
            2'b01:   w_load = r_unsigned ? {{(DATA_WIDTH-16){1'b0}}, w_lane_h}
                                         : {{(DATA_WIDTH-16){w_lane_h[15]}}, w_lane_h};
            default: w_load = r_rdata;
        endcase
    end

    // ------------------------------------------------------------------------
    // Datapath registers. mem_addr/mem_wdata hold their last values between
    // accesses; faulted requests leave them untouched.
    // ------------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_we        <= 1'b0;
            r_size      <= 2'b00;
            r_unsigned  <= 1'b0;
            r_addr_lo   <= 2'b00;
            r_wdata_lo  <= '0;
            r_mis       <= 1'b0;
            r_cnt       <= '0;
            r_rdata     <= '0;
            r_mem_addr  <= '0;
            r_mem_wdata <= '0;
        end else begin
            if (w_accept) begin
                r_we       <= req_we;
                r_size     <= req_size;
                r_unsigned <= req_unsigned;
                r_addr_lo  <= req_addr[1:0];
                r_wdata_lo <= req_wdata[15:0];
                r_mis      <= w_req_mis;
                r_cnt      <= '0;
                if (!w_req_mis) begin
                    r_mem_addr <= {req_addr[ADDR_WIDTH-1:2], 2'b00};
                    if (w_word_store) begin
                        r_mem_wdata <= req_wdata;
                    end
                end
            end
            if ((r_state == S_RD_WAIT) && !w_rd_done) begin
                r_cnt <= r_cnt + 3'd1;
            end
            // Edge ending the last RD_WAIT cycle: read data is valid here.
            if (w_rd_done) begin
                r_rdata <= mem_rdata;
                if (r_we) begin
                    r_mem_wdata <= w_merge;
                end
            end
        end
    end

endmodule
`default_nettype wire
